// File: rtl/exp_pkg.sv
// Shared constants, state encoding and ln(1-2^-k) table for the shift-and-add exponential.
package exp_pkg;

    localparam int ONE_Q8  = 256;
    localparam int MIN_X   = -256;
    localparam int N_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry i holds round(ln(1 - 2^-(i+1)) * 256) in Q2.8.
    localparam logic signed [10:0] LN_LUT [8] = '{
        -11'sd177, -11'sd74, -11'sd34, -11'sd17,
        -11'sd8,   -11'sd4,  -11'sd2,  -11'sd1
    };

endpackage

// File: rtl/exp_lut.sv
// Combinational ln(1-2^-k) lookup; k_idx = k-1 so k in 1..8 fits three bits.
module exp_lut
    import exp_pkg::*;
(
    input  logic [2:0]         k_idx,
    output logic signed [10:0] ln_k
);

    assign ln_k = LN_LUT[k_idx];

endmodule

// File: rtl/exp_sa.sv
// Iterative shift-and-add e^x for Q2.8 x in [-1.0, 0.0]; fixed 16-step latency.
// Handshake: start is accepted only in IDLE/DONE; done is a level that holds y/range_err until the next accepted start.
module exp_sa
    import exp_pkg::*;
#(
    parameter int W     = 10,
    parameter int FRAC  = 8,
    parameter int GUARD = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x0,
    output logic [W-1:0] y,
    output logic         done,
    output logic         busy,
    output logic         range_err,
    output state_e       state
);

    localparam int AW = 2 + FRAC + GUARD;
    localparam int RW = W + 1;
    localparam logic signed [W-1:0] MIN_XW = W'(MIN_X);

    logic [3:0]           step;
    logic [3:0]           shamt;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] r_nxt;
    logic signed [RW-1:0] ln_k;
    logic [AW-1:0]        yacc;
    logic [AW-1:0]        yacc_nxt;
    logic [W-1:0]         y_rnd;
    logic signed [W-1:0]  x_s;
    logic                 apply;

    exp_lut u_lut (
        .k_idx (step[3:1]),
        .ln_k  (ln_k)
    );

    assign x_s   = signed'(x0);
    assign shamt = {1'b0, step[3:1]} + 4'd1;
    assign apply = (r <= ln_k);

    // Each step of k is tried twice; both attempts share the same greedy rule.
    always_comb begin
        r_nxt    = r;
        yacc_nxt = yacc;
        if (apply) begin
            r_nxt    = r - ln_k;
            yacc_nxt = yacc - (yacc >> shamt);
        end
    end

    // Round-half-up of the post-step accumulator so the final step is included.
    assign y_rnd = W'((yacc_nxt + AW'(1 << (GUARD - 1))) >> GUARD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            r         <= '0;
            yacc      <= '0;
            y         <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (!x_s[W-1] && (x_s != '0)) begin
                            r         <= '0;
                            range_err <= 1'b1;
                        end else if (x_s < MIN_XW) begin
                            r         <= {MIN_XW[W-1], MIN_XW};
                            range_err <= 1'b1;
                        end else begin
                            r         <= {x_s[W-1], x_s};
                            range_err <= 1'b0;
                        end
                        yacc  <= AW'(1) << (FRAC + GUARD);
                        step  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r    <= r_nxt;
                    yacc <= yacc_nxt;
                    step <= step + 4'd1;
                    if (step == 4'(N_STEPS - 1)) begin
                        y     <= y_rnd;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_sa.sv
// Bench for exp_sa: directed scenarios plus a full-domain sweep against a real-valued e^x model.
module tb_exp_sa;
    import exp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] x0;
    logic [9:0] y;
    logic       done;
    logic       busy;
    logic       range_err;
    state_e     state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_lo_q[$];
    logic [9:0] exp_hi_q[$];
    logic       exp_err_q[$];

    exp_sa dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0),
        .y         (y),
        .done      (done),
        .busy      (busy),
        .range_err (range_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Start pulse covers one rising edge; returns at the negedge after the capture edge.
    task automatic do_start(input logic [9:0] x);
        @(negedge clk);
        start = 1'b1;
        x0    = x;
        @(negedge clk);
        start = 1'b0;
        x0    = 10'($urandom_range(0, 1023));
    endtask

    // cyc = rising edges since capture when done was first seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic sb_push_model(input int xi);
        real xr;
        real ideal;
        if (xi > 0)         xr = 0.0;
        else if (xi < -256) xr = -256.0;
        else                xr = real'(xi);
        ideal = 256.0 * $exp(xr / 256.0);
        exp_lo_q.push_back(10'(int'($ceil(ideal - 2.0))));
        exp_hi_q.push_back(10'(int'($floor(ideal + 2.0))));
        exp_err_q.push_back(xi > 0 || xi < -256);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        x0    = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (y !== 10'd0)     begin n_fail++; $display("FAIL reset_y: got %0d want 0", y); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", range_err); end
        n_checks++; if (state !== IDLE)  begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [9:0] lo, hi;
        logic       er;
        exp_lo_q.push_back(10'd256);
        exp_hi_q.push_back(10'd256);
        exp_err_q.push_back(1'b0);
        do_start(10'h000);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_busy_c%0d: got busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_latency: got done=%b busy=%b want done=1 busy=0", done, busy); end
        lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
        n_checks++; if (y < lo || y > hi) begin n_fail++; $display("FAIL zero_y: got %0d want [%0d,%0d]", y, lo, hi); end
        n_checks++; if (range_err !== er) begin n_fail++; $display("FAIL zero_err: got %b want %b", range_err, er); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b1 || y !== 10'd256) begin n_fail++; $display("FAIL zero_hold: got busy=%b done=%b y=%0d want 0 1 256", busy, done, y); end
    endtask

    task automatic test_points();
        int         xs[6]  = '{-128, -256, -300, 50, -512, 511};
        int         los[6] = '{153, 92, 92, 256, 92, 256};
        int         his[6] = '{157, 96, 96, 256, 96, 256};
        logic       ers[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [9:0] lo, hi, y_m256;
        logic       er;
        int         cyc;
        y_m256 = '0;
        for (int i = 0; i < 6; i++) begin
            exp_lo_q.push_back(10'(los[i]));
            exp_hi_q.push_back(10'(his[i]));
            exp_err_q.push_back(ers[i]);
            do_start(10'(xs[i]));
            wait_done(cyc);
            n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL pt_latency_x%0d: got %0d want 16", xs[i], cyc); end
            lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
            n_checks++; if (y < lo || y > hi) begin n_fail++; $display("FAIL pt_y_x%0d: got %0d want [%0d,%0d]", xs[i], y, lo, hi); end
            n_checks++; if (range_err !== er) begin n_fail++; $display("FAIL pt_err_x%0d: got %b want %b", xs[i], range_err, er); end
            if (xs[i] == -256) y_m256 = y;
            if (xs[i] == -300) begin
                n_checks++; if (y !== y_m256) begin n_fail++; $display("FAIL pt_clamp_same: got %0d want %0d", y, y_m256); end
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [9:0] lo, hi;
        logic       er;
        int         cyc;
        sb_push_model(-200);
        do_start(10'(-200));
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == 3 || cyc == 10) begin
                start = 1'b1;
                x0    = 10'h000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL ign_latency: got %0d want 16", cyc); end
        lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
        n_checks++; if (y < lo || y > hi) begin n_fail++; $display("FAIL ign_y: got %0d want [%0d,%0d]", y, lo, hi); end
        n_checks++; if (range_err !== er) begin n_fail++; $display("FAIL ign_err: got %b want %b", range_err, er); end
    endtask

    task automatic test_back_to_back();
        int         xs[2]  = '{-64, -32};
        logic [9:0] lo, hi;
        logic       er;
        int         cyc;
        exp_lo_q.push_back(10'd197);
        exp_hi_q.push_back(10'd201);
        exp_err_q.push_back(1'b0);
        sb_push_model(-32);
        for (int i = 0; i < 2; i++) begin
            do_start(10'(xs[i]));
            n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_drop_x%0d: got done=%b busy=%b want 0 1", xs[i], done, busy); end
            wait_done(cyc);
            n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL b2b_latency_x%0d: got %0d want 16", xs[i], cyc); end
            lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
            n_checks++; if (y < lo || y > hi) begin n_fail++; $display("FAIL b2b_y_x%0d: got %0d want [%0d,%0d]", xs[i], y, lo, hi); end
            n_checks++; if (range_err !== er) begin n_fail++; $display("FAIL b2b_err_x%0d: got %b want %b", xs[i], range_err, er); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] lo, hi;
        logic       er;
        int         cyc;
        do_start(10'(-300));
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (y !== 10'd0 || done !== 1'b0 || busy !== 1'b0 || range_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outs: got y=%0d done=%b busy=%b err=%b want all 0", y, done, busy, range_err);
        end
        n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want %0d", state, IDLE); end
        rst = 1'b1; start = 1'b1; x0 = 10'(-64);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++; if (state !== IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL rst_beats_start: got state=%0d busy=%b want %0d 0", state, busy, IDLE); end
        exp_lo_q.push_back(10'd197);
        exp_hi_q.push_back(10'd201);
        exp_err_q.push_back(1'b0);
        do_start(10'(-64));
        wait_done(cyc);
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL midrst_latency: got %0d want 16", cyc); end
        lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
        n_checks++; if (y < lo || y > hi) begin n_fail++; $display("FAIL midrst_y: got %0d want [%0d,%0d]", y, lo, hi); end
        n_checks++; if (range_err !== er) begin n_fail++; $display("FAIL midrst_err: got %b want %b", range_err, er); end
    endtask

    task automatic test_sweep();
        logic [9:0] lo, hi, prev;
        logic       er;
        int         cyc;
        prev = '0;
        for (int x = -256; x <= 0; x++) begin
            sb_push_model(x);
            do_start(10'(x));
            wait_done(cyc);
            n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL sweep_latency_x%0d: got %0d want 16", x, cyc); end
            lo = exp_lo_q.pop_front(); hi = exp_hi_q.pop_front(); er = exp_err_q.pop_front();
            n_checks++; if (y < lo || y > hi || range_err !== er) begin
                n_fail++; $display("FAIL sweep_y_x%0d: got y=%0d err=%b want [%0d,%0d] err=%b", x, y, range_err, lo, hi, er);
            end
            if (x > -256) begin
                n_checks++; if (y < prev) begin n_fail++; $display("FAIL sweep_mono_x%0d: got %0d want >= %0d", x, y, prev); end
            end
            prev = y;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_points();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        n_checks++; if (exp_lo_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d want 0", exp_lo_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
